serial_tx_ce: RTL and testbench

Serial transmitter that takes a parallel word through a valid/ready handshake and shifts it out on a single line as a framed bit stream: start bit, data LSB first, optional parity, one or two stop bits. Bit timing comes from an externally supplied clock-enable strobe, one bit per CE pulse, so the block runs at any bit rate the surrounding logic derives. It is the transmit-side counterpart to the team's CE-gated capture flip-flops. It sits between fabric logic producing bytes and an output pad or serial link.

---
 rtl/serial_tx_pkg.sv | 25 ++
 rtl/serial_tx_shreg.sv | 28 ++
 rtl/serial_tx_ce.sv | 148 ++++++++++++++
 tb/tb_serial_tx_ce.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the CE-paced serial transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to count 0..n-1; never less than one so a 1-bit frame still has a counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_tx_shreg.sv
// Data shift register: parallel load on acceptance, right shift per transmitted data bit.
module serial_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i)       sh_d = d_i;
    else if (shift_i) sh_d = sh_q >> 1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sh_q <= '0;
    else         sh_q <= sh_d;
  end

  assign lsb_o = sh_q[0];

endmodule

// File: rtl/serial_tx_ce.sv
// Framed serial transmitter: start, LSB-first data, optional parity, 1-2 stop bits, one bit per CE.
module serial_tx_ce
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH  = 8,
  parameter logic IDLE   = 1'b1,
  parameter int   PARITY = 0,
  parameter int   STOPS  = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic             RDY,
  output logic             Q,
  output logic             BUSY
);

  localparam int            CW        = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic          STOP_LAST = (STOPS == 2);

  if (WIDTH < 1 || WIDTH > 16 || PARITY < 0 || PARITY > 2 || (STOPS != 1 && STOPS != 2))
  begin : g_cfg_err
    $error("serial_tx_ce: parameter out of range");
  end

  tx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stp_q, stp_d;
  logic          par_q, par_d;
  logic          q_q, q_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          load, shift, sh_lsb;

  // RDY is only ever high in IDLE, so it alone qualifies acceptance.
  assign load  = rdy_q && DV;
  // Shifting on the START edge too keeps the next data bit sitting in the LSB.
  assign shift = CE && (st_q == ST_START || st_q == ST_DATA);

  serial_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk_i   (C),
    .rst_ni  (R),
    .load_i  (load),
    .shift_i (shift),
    .d_i     (D),
    .lsb_o   (sh_lsb)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    stp_d  = stp_q;
    par_d  = par_q;
    q_d    = q_q;
    rdy_d  = rdy_q;
    busy_d = busy_q;
    case (st_q)
      ST_IDLE: begin
        if (load) begin
          par_d  = (PARITY == PAR_ODD) ? ~(^D) : ^D;
          rdy_d  = 1'b0;
          busy_d = 1'b1;
          st_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (CE) begin
          q_d  = ~IDLE;
          st_d = ST_START;
        end
      end
      ST_START: begin
        if (CE) begin
          q_d   = sh_lsb;
          cnt_d = '0;
          st_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (CE) begin
          if (cnt_q < LAST_BIT) begin
            q_d   = sh_lsb;
            cnt_d = cnt_q + CW'(1);
          end else if (PARITY != PAR_NONE) begin
            q_d  = par_q;
            st_d = ST_PAR;
          end else begin
            q_d   = IDLE;
            stp_d = 1'b0;
            st_d  = ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (CE) begin
          q_d   = IDLE;
          stp_d = 1'b0;
          st_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (CE) begin
          if (stp_q == STOP_LAST) begin
            rdy_d  = 1'b1;
            busy_d = 1'b0;
            st_d   = ST_IDLE;
          end else begin
            stp_d = 1'b1;
          end
        end
      end
      default: begin
        q_d    = IDLE;
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (!R) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      stp_q  <= 1'b0;
      par_q  <= 1'b0;
      q_q    <= IDLE;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      stp_q  <= stp_d;
      par_q  <= par_d;
      q_q    <= q_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign RDY  = rdy_q;
  assign Q    = q_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_tx_ce.sv
// Directed bench: three parity/stop configurations sharing one stimulus bus.
module tb_serial_tx_ce;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       CE = 1'b0;
  logic       DV = 1'b0;
  logic [7:0] D = 8'h00;
  logic       rdy0, q0, busy0;
  logic       rdy1, q1, busy1;
  logic       rdy2, q2, busy2;
  int         checks = 0;
  int         errors = 0;

  always #5 C = ~C;

  serial_tx_ce #(.WIDTH(8), .IDLE(1'b1), .PARITY(1), .STOPS(1)) u_even (
    .C(C), .R(R), .CE(CE), .D(D), .DV(DV), .RDY(rdy0), .Q(q0), .BUSY(busy0));
  serial_tx_ce #(.WIDTH(8), .IDLE(1'b1), .PARITY(2), .STOPS(2)) u_odd2 (
    .C(C), .R(R), .CE(CE), .D(D), .DV(DV), .RDY(rdy1), .Q(q1), .BUSY(busy1));
  serial_tx_ce #(.WIDTH(8), .IDLE(1'b1), .PARITY(0), .STOPS(1)) u_none (
    .C(C), .R(R), .CE(CE), .D(D), .DV(DV), .RDY(rdy2), .Q(q2), .BUSY(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic do_reset;
    R = 1'b0;
    tick();
    R = 1'b1;
  endtask

  logic [0:10] e1;
  logic [0:11] e2;
  logic [0:9]  e3;
  logic        prev;

  initial begin
    e1 = 11'b01010010101;   // A5, even parity 0
    e2 = 12'b010000000011;  // 01, odd parity 0, two stops
    e3 = 10'b0001111001;    // 3C, no parity

    // reset state
    tick();
    chk("rst_q0", q0, 1); chk("rst_rdy0", rdy0, 1); chk("rst_busy0", busy0, 0);
    chk("rst_q1", q1, 1); chk("rst_q2", q2, 1);
    R = 1'b1;

    // even parity, CE held high; CE in acceptance cycle not consumed
    CE = 1'b1;
    do_reset();
    D = 8'hA5; DV = 1'b1;
    tick();
    DV = 1'b0;
    chk("t1_acc_q", q0, 1); chk("t1_acc_rdy", rdy0, 0); chk("t1_acc_busy", busy0, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t1_q", q0, e1[i]);
      chk("t1_busy", busy0, 1);
    end
    chk("t1_rdy_pre", rdy0, 0);
    tick();
    chk("t1_rdy", rdy0, 1); chk("t1_busy_end", busy0, 0); chk("t1_q_end", q0, 1);

    // odd parity, two stops, CE every 4th cycle
    CE = 1'b0;
    do_reset();
    D = 8'h01; DV = 1'b1;
    tick();
    DV = 1'b0;
    chk("t2_acc_rdy", rdy1, 0);
    prev = 1'b1;
    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < 4; c++) begin
        CE = (c == 3);
        tick();
        chk("t2_q", q1, (c == 3) ? e2[b] : prev);
      end
      prev = e2[b];
    end
    chk("t2_rdy_pre", rdy1, 0); chk("t2_busy_pre", busy1, 1);
    for (int c = 0; c < 4; c++) begin
      CE = (c == 3);
      tick();
    end
    CE = 1'b0;
    chk("t2_rdy", rdy1, 1); chk("t2_busy_end", busy1, 0); chk("t2_q_end", q1, 1);

    // no parity, DV held high with new data during frame
    CE = 1'b1;
    do_reset();
    D = 8'h3C; DV = 1'b1;
    tick();
    D = 8'hFF;
    chk("t3_acc_rdy", rdy2, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_q", q2, e3[i]);
      chk("t3_rdy_low", rdy2, 0);
    end
    tick();
    chk("t3_rdy", rdy2, 1); chk("t3_busy", busy2, 0); chk("t3_q_idle", q2, 1);
    tick();
    chk("t3_acc2_rdy", rdy2, 0); chk("t3_acc2_busy", busy2, 1); chk("t3_acc2_q", q2, 1);
    tick();
    chk("t3_start2", q2, 0);
    tick();
    chk("t3_d0_2", q2, 1);
    DV = 1'b0;

    // reset after the 4th data bit
    do_reset();
    D = 8'h00; DV = 1'b1;
    tick();
    DV = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_pre_q", q2, 0); chk("t4_pre_busy", busy2, 1);
    R = 1'b0;
    tick();
    R = 1'b1;
    chk("t4_q", q2, 1); chk("t4_rdy", rdy2, 1); chk("t4_busy", busy2, 0);
    for (int i = 0; i < 10; i++) begin
      CE = i[0];
      tick();
      chk("t4_hold_q", q2, 1);
      chk("t4_hold_rdy", rdy2, 1);
    end

    // acceptance coincident with a single CE
    CE = 1'b0;
    do_reset();
    D = 8'h3C; DV = 1'b1; CE = 1'b1;
    tick();
    DV = 1'b0; CE = 1'b0;
    chk("t5_acc_q", q2, 1); chk("t5_acc_rdy", rdy2, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_wait_q", q2, 1);
    end
    CE = 1'b1;
    tick();
    CE = 1'b0;
    chk("t5_start", q2, 0);

    // idle with CE toggling
    do_reset();
    DV = 1'b0;
    for (int i = 0; i < 100; i++) begin
      CE = i[0];
      tick();
      chk("t6_q0", q0, 1); chk("t6_rdy0", rdy0, 1); chk("t6_busy0", busy0, 0);
      chk("t6_q1", q1, 1); chk("t6_q2", q2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
